// File: rtl/ascii_dec_load_ctrl.sv
// ASCII decimal number accumulator: converts a digit stream ending in TERM_CHAR into an
// 8-bit value, pulses a one-cycle load into the downstream register, then presents result/status.
module ascii_dec_load_ctrl #(
   parameter int          MAX_DIGITS = 3,
   parameter logic [7:0]  TERM_CHAR  = 8'h0D
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       en_reg,
   output logic [7:0] reg_data,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic [1:0] out_err,
   input  logic       out_ready,
   output logic       busy
);

   // Handshakes: a character moves when in_valid & in_ready are both high at a rising edge;
   // a result moves when out_valid & out_ready are both high. Data is held until it moves.

   localparam int CW = $clog2(MAX_DIGITS + 1);

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_CHAR = 2'b01;
   localparam logic [1:0] ERR_OVF  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ACCUM = 3'd1,
      S_FLUSH = 3'd2,
      S_LOAD  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      err_q, err_d;

   logic            xfer_in;
   logic            is_digit;
   logic            is_term;
   logic [7:0]      digit_full;
   logic [3:0]      digit;
   logic [11:0]     nxt;
   logic            ovf;

   assign is_digit   = (in_data >= 8'h30) && (in_data <= 8'h39);
   assign is_term    = (in_data == TERM_CHAR);
   assign digit_full = in_data - 8'h30;
   assign digit      = digit_full[3:0];
   // Wide enough that acc*10+d can never wrap, so the range check is exact.
   assign nxt        = (12'(acc_q) * 12'd10) + 12'(digit);
   assign ovf        = (nxt > 12'd255) || (cnt_q == CW'(MAX_DIGITS));

   // Outputs decode the registered state only; reset forces everything quiet.
   always_comb begin
      in_ready  = 1'b0;
      en_reg    = 1'b0;
      reg_data  = 8'h00;
      out_valid = 1'b0;
      out_data  = 8'h00;
      out_err   = ERR_NONE;
      busy      = 1'b0;
      if (!reset) begin
         in_ready  = (state_q == S_IDLE) || (state_q == S_ACCUM) || (state_q == S_FLUSH);
         en_reg    = (state_q == S_LOAD);
         reg_data  = (state_q == S_LOAD) ? acc_q : 8'h00;
         out_valid = (state_q == S_DONE);
         out_data  = ((state_q == S_DONE) && (err_q == ERR_NONE)) ? acc_q : 8'h00;
         out_err   = (state_q == S_DONE) ? err_q : ERR_NONE;
         busy      = (state_q != S_IDLE);
      end
   end

   assign xfer_in = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (xfer_in) begin
               if (is_digit) begin
                  acc_d   = {4'h0, digit};
                  cnt_d   = CW'(1);
                  state_d = S_ACCUM;
               end else if (!is_term) begin
                  err_d   = ERR_CHAR;
                  state_d = S_FLUSH;
               end
            end
         end
         S_ACCUM: begin
            if (xfer_in) begin
               if (is_digit) begin
                  if (ovf) begin
                     err_d   = ERR_OVF;
                     state_d = S_FLUSH;
                  end else begin
                     acc_d = nxt[7:0];
                     cnt_d = cnt_q + CW'(1);
                  end
               end else if (is_term) begin
                  state_d = S_LOAD;
               end else begin
                  err_d   = ERR_CHAR;
                  state_d = S_FLUSH;
               end
            end
         end
         // Error already latched; swallow the rest of the number up to its terminator.
         S_FLUSH: begin
            if (xfer_in && is_term) begin
               state_d = S_DONE;
            end
         end
         S_LOAD: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               acc_d   = 8'h00;
               cnt_d   = '0;
               err_d   = ERR_NONE;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         acc_q   <= 8'h00;
         cnt_q   <= '0;
         err_q   <= ERR_NONE;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_ascii_dec_load_ctrl.sv
// Bench for ascii_dec_load_ctrl: table vectors, hand-timed corner sequences and random
// character streams scored against a number-level reference model.
module tb_ascii_dec_load_ctrl;

   localparam int         MAX_DIGITS = 3;
   localparam logic [7:0] CR         = 8'h0D;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       en_reg;
   logic [7:0] reg_data;
   logic       out_valid;
   logic [7:0] out_data;
   logic [1:0] out_err;
   logic       out_ready;
   logic       busy;

   ascii_dec_load_ctrl #(.MAX_DIGITS(MAX_DIGITS), .TERM_CHAR(CR)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .en_reg   (en_reg),
      .reg_data (reg_data),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_err  (out_err),
      .out_ready(out_ready),
      .busy     (busy)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // ---------------- scoreboard ----------------
   logic [7:0] exp_en_q[$];
   logic [9:0] exp_res_q[$];
   int         en_cnt;
   int         res_cnt;
   logic [7:0] last_reg;
   logic [9:0] last_res;
   bit         rand_or = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: walks the character stream number by number using integer arithmetic.
   function automatic void model_push(input logic [7:0] chars[$]);
      bit         active = 1'b0;
      int         value  = 0;
      int         count  = 0;
      int         err    = 0;
      logic [7:0] c;
      foreach (chars[i]) begin
         c = chars[i];
         if (!active) begin
            if (c == CR) continue;
            active = 1'b1;
            value  = 0;
            count  = 0;
            err    = 0;
         end
         if (c == CR) begin
            if (err == 0) exp_en_q.push_back(value[7:0]);
            exp_res_q.push_back({2'(err), (err == 0) ? value[7:0] : 8'h00});
            active = 1'b0;
         end else if (err != 0) begin
            // characters after the first error are dropped
         end else if (c >= 8'h30 && c <= 8'h39) begin
            if (count == MAX_DIGITS) begin
               err = 2;
            end else begin
               value = value * 10 + int'(c - 8'h30);
               count++;
               if (value > 255) err = 2;
            end
         end else begin
            err = 1;
         end
      end
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         if (en_reg) begin
            en_cnt++;
            last_reg = reg_data;
            if (exp_en_q.size() == 0) begin
               check("en_unexpected", 32'(reg_data), 32'hFFFF_FFFF);
            end else begin
               check("en_data", 32'(reg_data), 32'(exp_en_q.pop_front()));
            end
         end else begin
            check("reg_data_idle_zero", 32'(reg_data), 32'h0);
         end
         if (out_valid && out_ready) begin
            res_cnt++;
            last_res = {out_err, out_data};
            if (exp_res_q.size() == 0) begin
               check("res_unexpected", 32'({out_err, out_data}), 32'hFFFF_FFFF);
            end else begin
               check("res_value", 32'({out_err, out_data}), 32'(exp_res_q.pop_front()));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_or) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_char(input logic [7:0] c);
      int t = 0;
      in_valid = 1'b1;
      in_data  = c;
      @(negedge clk);
      while (!in_ready && t < 200) begin
         tick();
         @(negedge clk);
         t++;
      end
      if (!in_ready) check("send_timeout", 32'(in_ready), 32'h1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while (busy && t < 200) begin
         tick();
         @(negedge clk);
         t++;
      end
      if (busy) check("idle_timeout", 32'(busy), 32'h0);
      tick();
   endtask

   task automatic run_q(input logic [7:0] q[$], input int gap_max);
      model_push(q);
      en_cnt  = 0;
      res_cnt = 0;
      foreach (q[i]) begin
         repeat ($urandom_range(0, gap_max)) tick();
         send_char(q[i]);
      end
      wait_idle();
   endtask

   task automatic run_stream(input string s);
      logic [7:0] q[$];
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      run_q(q, 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string      s;
      int         n_en;
      logic [7:0] en_data;
      int         n_res;
      logic [7:0] res_data;
      logic [1:0] res_err;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{"123\015",   1, 8'h7B, 1, 8'h7B, 2'b00};
      vecs[1] = '{"255\015",   1, 8'hFF, 1, 8'hFF, 2'b00};
      vecs[2] = '{"256\015",   0, 8'h00, 1, 8'h00, 2'b10};
      vecs[3] = '{"0007\015",  0, 8'h00, 1, 8'h00, 2'b10};
      vecs[4] = '{"1A2\015",   0, 8'h00, 1, 8'h00, 2'b01};
      vecs[5] = '{"1A999\015", 0, 8'h00, 1, 8'h00, 2'b01};
      vecs[6] = '{"000\015",   1, 8'h00, 1, 8'h00, 2'b00};
      vecs[7] = '{"\015",      0, 8'h00, 0, 8'h00, 2'b00};

      // Reset state, with a character offered to confirm in_ready stays low.
      reset     = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h31;
      out_ready = 1'b1;
      en_cnt    = 0;
      res_cnt   = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready",  32'(in_ready),  32'h0);
      check("rst_en_reg",    32'(en_reg),    32'h0);
      check("rst_reg_data",  32'(reg_data),  32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_data",  32'(out_data),  32'h0);
      check("rst_out_err",   32'(out_err),   32'h0);
      check("rst_busy",      32'(busy),      32'h0);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      tick();

      // Cycle-exact latency: en_reg after CR, out_valid the cycle after, IDLE the next.
      begin
         logic [7:0] q[$];
         q = '{8'h31, 8'h32, 8'h33, CR};
         model_push(q);
         send_char(8'h31);
         send_char(8'h32);
         send_char(8'h33);
         send_char(CR);
         @(negedge clk);
         check("lat_en_reg",     32'(en_reg),    32'h1);
         check("lat_reg_data",   32'(reg_data),  32'h7B);
         check("lat_in_ready_l", 32'(in_ready),  32'h0);
         check("lat_no_valid",   32'(out_valid), 32'h0);
         @(negedge clk);
         check("lat_en_off",     32'(en_reg),    32'h0);
         check("lat_out_valid",  32'(out_valid), 32'h1);
         check("lat_out_data",   32'(out_data),  32'h7B);
         check("lat_out_err",    32'(out_err),   32'h0);
         @(negedge clk);
         check("lat_ready_back", 32'(in_ready),  32'h1);
         check("lat_busy_low",   32'(busy),      32'h0);
         tick();
      end

      foreach (vecs[i]) begin
         run_stream(vecs[i].s);
         check($sformatf("vec%0d_en_cnt", i), 32'(en_cnt), 32'(vecs[i].n_en));
         if (vecs[i].n_en > 0) check($sformatf("vec%0d_reg_data", i), 32'(last_reg), 32'(vecs[i].en_data));
         check($sformatf("vec%0d_res_cnt", i), 32'(res_cnt), 32'(vecs[i].n_res));
         if (vecs[i].n_res > 0)
            check($sformatf("vec%0d_result", i), 32'(last_res), 32'({vecs[i].res_err, vecs[i].res_data}));
      end

      // Lone terminator leaves the controller idle.
      send_char(CR);
      @(negedge clk);
      check("lone_cr_busy",  32'(busy),      32'h0);
      check("lone_cr_valid", 32'(out_valid), 32'h0);
      tick();

      // Back-pressure: result held stable while out_ready is low, extra char not consumed.
      begin
         logic [7:0] q[$];
         q = '{8'h34, 8'h32, CR};
         model_push(q);
         en_cnt    = 0;
         res_cnt   = 0;
         out_ready = 1'b0;
         send_char(8'h34);
         send_char(8'h32);
         send_char(CR);
         in_valid = 1'b1;
         in_data  = 8'h39;
         @(negedge clk);
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'h1);
            check("hold_out_data",  32'(out_data),  32'h2A);
            check("hold_out_err",   32'(out_err),   32'h0);
            check("hold_in_ready",  32'(in_ready),  32'h0);
         end
         tick();
         out_ready = 1'b1;
         in_valid  = 1'b0;
         @(negedge clk);
         @(negedge clk);
         check("hold_released", 32'(out_valid), 32'h0);
         check("hold_en_cnt",   32'(en_cnt),    32'h1);
         check("hold_res_cnt",  32'(res_cnt),   32'h1);
         tick();
      end

      // Reset in the middle of a number aborts it.
      en_cnt  = 0;
      res_cnt = 0;
      send_char(8'h31);
      send_char(8'h32);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_busy",     32'(busy),      32'h0);
      check("mid_rst_en",       32'(en_reg),    32'h0);
      check("mid_rst_in_ready", 32'(in_ready),  32'h0);
      check("mid_rst_valid",    32'(out_valid), 32'h0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'h0);
      tick();
      run_stream("7\015");
      check("post_rst_en_cnt", 32'(en_cnt),   32'h1);
      check("post_rst_result", 32'(last_res), 32'h007);

      // Random streams with idle gaps and random out_ready.
      rand_or = 1'b1;
      for (int n = 0; n < 40; n++) begin
         logic [7:0] q[$];
         int         len;
         int         r;
         len = $urandom_range(1, 6);
         for (int k = 0; k < len; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       q.push_back(8'h30 + 8'($urandom_range(0, 9)));
            else if (r == 7) q.push_back(CR);
            else             q.push_back(8'h41 + 8'($urandom_range(0, 25)));
         end
         q.push_back(CR);
         run_q(q, 2);
      end
      rand_or   = 1'b0;
      out_ready = 1'b1;
      tick();

      check("sb_en_drained",  32'(exp_en_q.size()),  32'h0);
      check("sb_res_drained", 32'(exp_res_q.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
